// File: rtl/v810_dmem.sv
// v810_dmem: single-port 32-bit data memory slave for the V810 CPU bus.
// Accepts one request at a time and sequences it through a fixed number
// of wait cycles before a one-cycle active-low acknowledge.
//
// State table:
//   IDLE  | waiting for MRQn=0; CPU inputs are sampled here only
//   WAITS | counting down the WAIT cycles on the latched request
//   ACK   | READYn low for one CE cycle; write committed on exit
//
// Parameters:
//   AW   - word-address bits, array is 2**AW x 32
//   WAIT - wait cycles before acknowledge (0..7)
//   BASE - decode base; the window is BASE[31:AW+2]
// Ports:
//   CLK, RESn (sync, active-low), CE (clock enable)
//   DA     byte address        DD_I  write data      DD_O  read data
//   BEn    active-low byte enables                   ST    bus status
//   MRQn   active-low request  RW    1=read 0=write
//   READYn active-low acknowledge                    ERR   decode miss
module v810_dmem #(
  parameter int          AW   = 10,
  parameter int          WAIT = 1,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] DA,
  input  logic [31:0] DD_I,
  output logic [31:0] DD_O,
  input  logic [3:0]  BEn,
  input  logic [1:0]  ST,
  input  logic        MRQn,
  input  logic        RW,
  output logic        READYn,
  output logic        ERR
);

  typedef enum logic [1:0] {IDLE, WAITS, ACK} state_t;

  localparam logic [2:0] WAIT_L = 3'(WAIT);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:2] da_q;
  logic        rw_q;
  logic [3:0]  ben_q;
  logic [31:0] dd_q;
  logic [1:0]  st_q;

  logic [31:0] mem [0:2**AW-1];

  // In IDLE the live bus is decoded so a WAIT=0 access can read at
  // acceptance; afterwards only the latched copy is used.
  logic [31:2]   acc_addr;
  logic          acc_rw;
  logic          acc_hit;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_data;
  logic          go_ack;
  logic          mem_we;

  assign acc_addr = (state == IDLE) ? DA[31:2] : da_q;
  assign acc_rw   = (state == IDLE) ? RW : rw_q;
  assign acc_hit  = (acc_addr[31:AW+2] == BASE[31:AW+2]);
  assign acc_idx  = acc_addr[AW+1:2];
  assign rd_data  = acc_hit ? mem[acc_idx] : 32'h0;

  // Edge that moves the FSM into ACK; the read is registered on it.
  assign go_ack = CE && (((state == IDLE) && !MRQn && (WAIT == 0)) ||
                         ((state == WAITS) && (cnt == 3'd1)));

  // Write commits on the ACK exit edge; reset on that edge aborts it.
  assign mem_we = RESn && CE && (state == ACK) && !rw_q && acc_hit;

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      READYn <= 1'b1;
      ERR    <= 1'b0;
      DD_O   <= 32'h0;
    end else if (CE) begin
      case (state)
        IDLE: begin
          if (!MRQn) begin
            da_q  <= DA[31:2];
            rw_q  <= RW;
            ben_q <= BEn;
            dd_q  <= DD_I;
            st_q  <= ST;
            cnt   <= WAIT_L;
            state <= (WAIT == 0) ? ACK : WAITS;
          end
        end
        WAITS: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= ACK;
        end
        ACK: begin
          state  <= IDLE;
          READYn <= 1'b1;
          ERR    <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (go_ack) begin
        READYn <= 1'b0;
        ERR    <= !acc_hit;
        if (acc_rw) DD_O <= rd_data;
      end
    end
  end

  // Array has no reset so its contents survive RESn.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!ben_q[b]) mem[acc_idx][8*b +: 8] <= dd_q[8*b +: 8];
      end
    end
  end

  // Bus status and byte offset are carried but have no function here.
  logic unused_bits;
  assign unused_bits = ^{st_q, DA[1:0]};

endmodule

// File: doc/v810_dmem.md
V810_DMEM -- requirements
Module: v810_dmem

Interface
REQ-001 The module SHALL expose the parameter AW, default 10, meaning the number of word-address bits; the array holds 2**AW 32-bit words.
REQ-002 The module SHALL expose the parameter WAIT, default 1, range 0..7, meaning the number of wait cycles inserted before acknowledge.
REQ-003 The module SHALL expose the parameter BASE, default 32'h0000_0000, meaning the decode base address.
REQ-004 The module SHALL have port CLK  in  1  system clock; the sole clock, all state changes on its rising edge.
REQ-005 The module SHALL have port RESn  in  1  reset; synchronous, active-low.
REQ-006 The module SHALL have port CE  in  1  clock enable; the state advances only on edges where CE=1.
REQ-007 The module SHALL have port DA  in  32  byte address from the CPU.
REQ-008 The module SHALL have port DD_I  in  32  write data, driven by the CPU's DD_O.
REQ-009 The module SHALL have port DD_O  out  32  read data, driving the CPU's DD_I.
REQ-010 The module SHALL have port BEn  in  4  active-low byte enables; bit n selects DD[8n+7:8n].
REQ-011 The module SHALL have port ST  in  2  bus status; it is ignored functionally but latched with the request.
REQ-012 The module SHALL have port MRQn  in  1  active-low memory request.
REQ-013 The module SHALL have port RW  in  1  direction; 1 = read, 0 = write.
REQ-014 The module SHALL have port READYn  out  1  active-low acknowledge, low for exactly one CE cycle per request.
REQ-015 The module SHALL have port ERR  out  1  one-cycle pulse, high with READYn when the access misses the decode window.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAITS and ACK.
REQ-017 In IDLE with MRQn=0 on a CE edge, the module SHALL latch DA, RW, BEn, DD_I and ST, and SHALL load the wait counter with WAIT.
- Next state is WAITS when WAIT>0, ACK when WAIT=0.
REQ-018 In WAITS, the counter SHALL decrement by 1 per CE edge; the state moves to ACK on the edge where the counter is 1.
REQ-019 MRQn and the CPU-side inputs SHALL be ignored in WAITS and ACK; only the latched copies are used.
REQ-020 In ACK, READYn SHALL be 0; on the ACK exit edge the state SHALL return to IDLE.
REQ-021 Latency: a request sampled at edge E SHALL see READYn low during the cycle after edge E+WAIT (in CE cycles).
- WAIT=0 gives READYn low in the very next cycle.
REQ-022 Back-to-back: a request presented in the first IDLE cycle after ACK SHALL be accepted with no extra idle cycle.
- Minimum throughput is WAIT+2 cycles per access.
REQ-023 Decode: the access SHALL hit when the latched DA[31:AW+2] equals BASE[31:AW+2]; the word index is DA[AW+1:2].
REQ-024 DA[1:0] SHALL be ignored.
REQ-025 Read hit: DD_O SHALL equal mem[index] during the ACK cycle.
- The array read is registered, issued in the cycle before ACK (or at acceptance when WAIT=0).
REQ-026 Write hit: on the ACK exit edge, the module SHALL write only the bytes with BEn[n]=0.
- BEn=4'hF SHALL write nothing and SHALL still acknowledge.
REQ-027 Miss, read: DD_O SHALL be 32'h0 during ACK.
REQ-028 Miss, write: the array SHALL be unchanged.
REQ-029 On any miss, ERR SHALL be 1 during ACK.
REQ-030 Outside ACK, DD_O SHALL hold its last value, READYn SHALL be 1 and ERR SHALL be 0.
REQ-031 With CE=0, all state, the counter and the outputs SHALL be frozen, including a READYn already low.

Reset
REQ-032 On a CLK edge with RESn=0 (regardless of CE), the state SHALL become IDLE and the counter 0.
- READYn=1, ERR=0, DD_O=32'h0.
REQ-033 Reset during WAITS or ACK SHALL abort the access; no array write SHALL occur on that edge.
REQ-034 Array contents SHALL NOT be cleared by reset.

Verification
REQ-035 Scenario: WAIT=0, write 32'hDEADBEEF to 0x10 with BEn=0, then read 0x10 -> READYn low one cycle after each request; read returns 32'hDEADBEEF.
REQ-036 Scenario: WAIT=3, read 0x0 -> READYn high for 3 cycles after acceptance, low in the 4th, high afterwards.
REQ-037 Scenario: write 32'h11223344 with BEn=0 to 0x20, then write 32'hAABBCCDD with BEn=4'b1010, then read 0x20 -> 32'h11BB33DD.
REQ-038 Scenario: AW=10, BASE=0, read from 0x0000_1000 -> READYn and ERR low/high together for one cycle; DD_O=0.
- Word 0 is unchanged after a write to the same address.
REQ-039 Scenario: WAIT=2, write request, RESn=0 asserted in the cycle before ACK -> no READYn pulse; target word unchanged; the next request is served normally.
REQ-040 Scenario: WAIT=1, CE toggled 1/0 every cycle during a read -> READYn low for exactly two CLK cycles (one CE cycle); data is correct.
